// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter
// Multi-host to multi-device interconnect. Round-robin arbitration picks one
// host per cycle, the granted host's address is decoded against per-device
// base/mask windows, and the response is routed back one cycle later.
//
// Handshake (host side): a host raises req with addr/we/be/wdata and must
// hold all of them stable until gnt is seen high in the same cycle; the
// transaction is accepted exactly in a cycle where req && gnt. Exactly one
// cycle later rvalid pulses for that host, carrying rdata/err. There is no
// back-pressure on the response path and no buffering inside the arbiter.
// Device side: req is a single-cycle strobe per accepted transaction, and
// the device answers with rvalid/rdata/err exactly one cycle after it.
module bus_rr_arbiter #(
  parameter int unsigned NrHosts      = 2,
  parameter int unsigned NrDevices    = 3,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned AddressWidth = 32,
  localparam int unsigned HostIdxW    = (NrHosts > 1) ? $clog2(NrHosts) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,

  input  logic                      host_req_i    [NrHosts],
  output logic                      host_gnt_o    [NrHosts],
  input  logic [AddressWidth-1:0]   host_addr_i   [NrHosts],
  input  logic                      host_we_i     [NrHosts],
  input  logic [DataWidth/8-1:0]    host_be_i     [NrHosts],
  input  logic [DataWidth-1:0]      host_wdata_i  [NrHosts],
  output logic                      host_rvalid_o [NrHosts],
  output logic [DataWidth-1:0]      host_rdata_o  [NrHosts],
  output logic                      host_err_o    [NrHosts],

  output logic                      device_req_o    [NrDevices],
  output logic [AddressWidth-1:0]   device_addr_o   [NrDevices],
  output logic                      device_we_o     [NrDevices],
  output logic [DataWidth/8-1:0]    device_be_o     [NrDevices],
  output logic [DataWidth-1:0]      device_wdata_o  [NrDevices],
  input  logic                      device_rvalid_i [NrDevices],
  input  logic [DataWidth-1:0]      device_rdata_i  [NrDevices],
  input  logic                      device_err_i    [NrDevices],

  input  logic [AddressWidth-1:0]   cfg_device_addr_base [NrDevices],
  input  logic [AddressWidth-1:0]   cfg_device_addr_mask [NrDevices],

  // Round-robin pointer, exposed for observation.
  output logic [HostIdxW-1:0]       dbg_rr_ptr_o
);

  localparam int unsigned DevIdxW = (NrDevices > 1) ? $clog2(NrDevices) : 1;

  // Host index 'off' positions above 'base', wrapping at NrHosts.
  function automatic logic [HostIdxW-1:0] wrap_idx(input logic [HostIdxW-1:0] base,
                                                   input int unsigned         off);
    int unsigned sum;
    sum = 32'(base) + off;
    return HostIdxW'(sum % NrHosts);
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [HostIdxW-1:0] rr_ptr_q;
  logic [HostIdxW-1:0] rr_ptr_d;

  logic                resp_valid_q;
  logic [HostIdxW-1:0] resp_host_q;
  logic [DevIdxW-1:0]  resp_dev_q;
  logic                resp_decerr_q;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic                gnt_any;
  logic [HostIdxW-1:0] gnt_idx;

  // Scan hosts starting at the pointer; the first requester wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int unsigned i = 0; i < NrHosts; i++) begin
      if (!gnt_any && host_req_i[wrap_idx(rr_ptr_q, i)]) begin
        gnt_any = 1'b1;
        gnt_idx = wrap_idx(rr_ptr_q, i);
      end
    end
  end

  // Pointer moves just past the winner; idle cycles leave it where it is.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_any) begin
      rr_ptr_d = wrap_idx(gnt_idx, 1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign dbg_rr_ptr_o = rr_ptr_q;

  // Grant outputs are forced low while reset is held.
  always_comb begin
    for (int unsigned h = 0; h < NrHosts; h++) begin
      host_gnt_o[h] = rst_ni && gnt_any && (gnt_idx == HostIdxW'(h));
    end
  end

  // ---------------------------------------------------------------------------
  // Granted host request mux
  // ---------------------------------------------------------------------------
  logic [AddressWidth-1:0] sel_addr;
  logic                    sel_we;
  logic [DataWidth/8-1:0]  sel_be;
  logic [DataWidth-1:0]    sel_wdata;

  // Select the winning host's request fields (host 0 when idle).
  always_comb begin
    sel_addr  = '0;
    sel_we    = 1'b0;
    sel_be    = '0;
    sel_wdata = '0;
    for (int unsigned h = 0; h < NrHosts; h++) begin
      if (gnt_idx == HostIdxW'(h)) begin
        sel_addr  = host_addr_i[h];
        sel_we    = host_we_i[h];
        sel_be    = host_be_i[h];
        sel_wdata = host_wdata_i[h];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic               dec_hit;
  logic [DevIdxW-1:0] dec_idx;

  // Lowest-index matching window wins when windows overlap.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int unsigned d = 0; d < NrDevices; d++) begin
      if (!dec_hit &&
          ((sel_addr & cfg_device_addr_mask[d]) == cfg_device_addr_base[d])) begin
        dec_hit = 1'b1;
        dec_idx = DevIdxW'(d);
      end
    end
  end

  // Strobe only the decoded device; payload is broadcast to all devices.
  always_comb begin
    for (int unsigned d = 0; d < NrDevices; d++) begin
      device_req_o[d]   = rst_ni && gnt_any && dec_hit && (dec_idx == DevIdxW'(d));
      device_addr_o[d]  = sel_addr;
      device_we_o[d]    = sel_we;
      device_be_o[d]    = sel_be;
      device_wdata_o[d] = sel_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Response tracking
  // ---------------------------------------------------------------------------
  // Remember who was granted and where the request went, for one cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      resp_valid_q  <= 1'b0;
      resp_host_q   <= '0;
      resp_dev_q    <= '0;
      resp_decerr_q <= 1'b0;
    end else begin
      resp_valid_q <= gnt_any;
      if (gnt_any) begin
        resp_host_q   <= gnt_idx;
        resp_dev_q    <= dec_idx;
        resp_decerr_q <= !dec_hit;
      end
    end
  end

  logic                 dev_rvalid_sel;
  logic [DataWidth-1:0] dev_rdata_sel;
  logic                 dev_err_sel;

  // Pick the response lines of the device that owns the pending request.
  always_comb begin
    dev_rvalid_sel = 1'b0;
    dev_rdata_sel  = '0;
    dev_err_sel    = 1'b0;
    for (int unsigned d = 0; d < NrDevices; d++) begin
      if (resp_dev_q == DevIdxW'(d)) begin
        dev_rvalid_sel = device_rvalid_i[d];
        dev_rdata_sel  = device_rdata_i[d];
        dev_err_sel    = device_err_i[d];
      end
    end
  end

  logic                 rsp_active;
  logic [DataWidth-1:0] rsp_rdata;
  logic                 rsp_err;

  // Build the response: decode errors and silent devices both report err
  // with zero data so the host never stalls waiting for rvalid.
  always_comb begin
    rsp_active = rst_ni && resp_valid_q;
    rsp_rdata  = '0;
    rsp_err    = 1'b0;
    if (resp_decerr_q) begin
      rsp_err = 1'b1;
    end else if (dev_rvalid_sel) begin
      rsp_rdata = dev_rdata_sel;
      rsp_err   = dev_err_sel;
    end else begin
      rsp_err = 1'b1;
    end
  end

  // Route the response to the recorded host; everyone else sees zeros.
  always_comb begin
    for (int unsigned h = 0; h < NrHosts; h++) begin
      host_rvalid_o[h] = rsp_active && (resp_host_q == HostIdxW'(h));
      host_rdata_o[h]  = (rsp_active && (resp_host_q == HostIdxW'(h))) ? rsp_rdata : '0;
      host_err_o[h]    = rsp_active && (resp_host_q == HostIdxW'(h)) && rsp_err;
    end
  end

`ifndef SYNTHESIS
  // A device may only answer the cycle after it was strobed.
  for (genvar d = 0; d < NrDevices; d++) begin : g_rvalid_chk
    a_no_spurious_rvalid : assert property (
      @(posedge clk_i) disable iff (!rst_ni)
      device_rvalid_i[d] |-> (resp_valid_q && !resp_decerr_q && (resp_dev_q == DevIdxW'(d))));
  end
`endif

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter: two hosts, three devices
// (RAM, sim ctrl, timer) modelled as one-cycle-latency responders.
module tb_bus_rr_arbiter;

  localparam int NH = 2;
  localparam int ND = 3;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------------------
  // DUT signals
  // ---------------------------------------------------------------------------
  logic        host_req    [NH];
  logic        host_gnt    [NH];
  logic [31:0] host_addr   [NH];
  logic        host_we     [NH];
  logic [3:0]  host_be     [NH];
  logic [31:0] host_wdata  [NH];
  logic        host_rvalid [NH];
  logic [31:0] host_rdata  [NH];
  logic        host_err    [NH];

  logic        dev_req    [ND];
  logic [31:0] dev_addr   [ND];
  logic        dev_we     [ND];
  logic [3:0]  dev_be     [ND];
  logic [31:0] dev_wdata  [ND];
  logic        dev_rvalid [ND];
  logic [31:0] dev_rdata  [ND];
  logic        dev_err    [ND];

  logic [31:0] cfg_base [ND];
  logic [31:0] cfg_mask [ND];
  logic        dbg_ptr;

  bus_rr_arbiter #(
    .NrHosts(NH), .NrDevices(ND), .DataWidth(32), .AddressWidth(32)
  ) dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .host_req_i          (host_req),
    .host_gnt_o          (host_gnt),
    .host_addr_i         (host_addr),
    .host_we_i           (host_we),
    .host_be_i           (host_be),
    .host_wdata_i        (host_wdata),
    .host_rvalid_o       (host_rvalid),
    .host_rdata_o        (host_rdata),
    .host_err_o          (host_err),
    .device_req_o        (dev_req),
    .device_addr_o       (dev_addr),
    .device_we_o         (dev_we),
    .device_be_o         (dev_be),
    .device_wdata_o      (dev_wdata),
    .device_rvalid_i     (dev_rvalid),
    .device_rdata_i      (dev_rdata),
    .device_err_i        (dev_err),
    .cfg_device_addr_base(cfg_base),
    .cfg_device_addr_mask(cfg_mask),
    .dbg_rr_ptr_o        (dbg_ptr)
  );

  // ---------------------------------------------------------------------------
  // Device models: answer one cycle after req with a fixed per-device word
  // ---------------------------------------------------------------------------
  logic [31:0] dev_word   [ND];
  logic        dev_silent [ND];

  initial begin
    dev_word[0] = 32'hDEADBEEF;
    dev_word[1] = 32'h5111C001;
    dev_word[2] = 32'h71330004;
    for (int d = 0; d < ND; d++) begin
      dev_silent[d] = 1'b0;
      dev_rvalid[d] = 1'b0;
      dev_rdata[d]  = '0;
      dev_err[d]    = 1'b0;
    end
  end

  always @(posedge clk) begin
    for (int d = 0; d < ND; d++) begin
      dev_rvalid[d] <= dev_req[d] && !dev_silent[d];
      dev_rdata[d]  <= dev_req[d] ? dev_word[d] : 32'h0;
      dev_err[d]    <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_vec;
  int n_err;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] gnt_v();
    return {30'd0, host_gnt[1], host_gnt[0]};
  endfunction

  function automatic logic [31:0] rv_v();
    return {30'd0, host_rvalid[1], host_rvalid[0]};
  endfunction

  function automatic logic [31:0] err_v();
    return {30'd0, host_err[1], host_err[0]};
  endfunction

  function automatic logic [31:0] dreq_v();
    return {29'd0, dev_req[2], dev_req[1], dev_req[0]};
  endfunction

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  task automatic drive(input int h, input logic req, input logic [31:0] addr, input logic we);
    host_req[h]   = req;
    host_addr[h]  = addr;
    host_we[h]    = we;
    host_be[h]    = 4'hF;
    host_wdata[h] = 32'hA5A50000 | h;
  endtask

  task automatic set_default_map();
    cfg_base[0] = 32'h00100000; cfg_mask[0] = 32'hFFF00000;  // RAM
    cfg_base[1] = 32'h00020000; cfg_mask[1] = 32'hFFFF0000;  // sim ctrl
    cfg_base[2] = 32'h00030000; cfg_mask[2] = 32'hFFFF0000;  // timer
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus: drive on negedge, check 1 time unit later
  // ---------------------------------------------------------------------------
  initial begin
    n_vec = 0;
    n_err = 0;
    set_default_map();
    rst_n = 1'b0;
    for (int h = 0; h < NH; h++) drive(h, 1'b1, 32'h00100040, 1'b0);

    // Reset held with every host requesting.
    repeat (2) begin
      @(negedge clk); #1;
      check("rst_gnt",    gnt_v(),  32'h0);
      check("rst_dreq",   dreq_v(), 32'h0);
      check("rst_rvalid", rv_v(),   32'h0);
      check("rst_err",    err_v(),  32'h0);
      check("rst_rdata0", host_rdata[0], 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int h = 0; h < NH; h++) drive(h, 1'b0, 32'h0, 1'b0);
    #1;
    check("rst_ptr", 32'(dbg_ptr), 32'h0);

    // Single read from RAM by host 0.
    @(negedge clk);
    drive(0, 1'b1, 32'h00100040, 1'b0);
    #1;
    check("rd_gnt",  gnt_v(),  32'h1);
    check("rd_dreq", dreq_v(), 32'h1);
    check("rd_addr", dev_addr[0], 32'h00100040);
    @(negedge clk);
    drive(0, 1'b0, 32'h0, 1'b0);
    #1;
    check("rd_rvalid", rv_v(), 32'h1);
    check("rd_rdata0", host_rdata[0], 32'hDEADBEEF);
    check("rd_err",    err_v(), 32'h0);
    check("rd_rdata1", host_rdata[1], 32'h0);
    check("rd_ptr",    32'(dbg_ptr), 32'h1);

    // Decode error: host 1 writes an unmapped address.
    @(negedge clk);
    drive(1, 1'b1, 32'h00050000, 1'b1);
    #1;
    check("de_gnt",  gnt_v(),  32'h2);
    check("de_dreq", dreq_v(), 32'h0);
    @(negedge clk);
    drive(1, 1'b0, 32'h0, 1'b0);
    #1;
    check("de_rvalid", rv_v(), 32'h2);
    check("de_err",    err_v(), 32'h2);
    check("de_rdata1", host_rdata[1], 32'h0);
    check("de_ptr",    32'(dbg_ptr), 32'h0);

    // Fairness: both hosts request continuously for six cycles.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) begin
        drive(0, 1'b1, 32'h00100040, 1'b0);
        drive(1, 1'b1, 32'h00100080, 1'b0);
      end
      #1;
      check($sformatf("rr_gnt%0d", k), gnt_v(), (k % 2 == 0) ? 32'h1 : 32'h2);
      if (k > 0) begin
        check($sformatf("rr_rv%0d", k), rv_v(), (k % 2 == 1) ? 32'h1 : 32'h2);
        check($sformatf("rr_rd%0d", k), host_rdata[(k - 1) % 2], 32'hDEADBEEF);
      end
    end
    @(negedge clk);
    drive(0, 1'b0, 32'h0, 1'b0);
    drive(1, 1'b0, 32'h0, 1'b0);
    #1;
    check("rr_rv_last", rv_v(), 32'h2);
    check("rr_rd_last", host_rdata[1], 32'hDEADBEEF);

    // Back-to-back: write to sim ctrl, then read timer, no bubble.
    @(negedge clk);
    drive(0, 1'b1, 32'h00020000, 1'b1);
    #1;
    check("bb_gnt0",  gnt_v(),  32'h1);
    check("bb_dreq0", dreq_v(), 32'h2);
    check("bb_we",    32'(dev_we[1]), 32'h1);
    check("bb_wdata", dev_wdata[1], 32'hA5A50000);
    exp_q.push_back(32'h5111C001);
    @(negedge clk);
    drive(0, 1'b1, 32'h00030004, 1'b0);
    #1;
    check("bb_gnt1",  gnt_v(),  32'h1);
    check("bb_dreq1", dreq_v(), 32'h4);
    check("bb_rv0",   rv_v(),   32'h1);
    check("bb_rd0",   host_rdata[0], exp_q.pop_front());
    exp_q.push_back(32'h71330004);
    @(negedge clk);
    drive(0, 1'b0, 32'h0, 1'b0);
    #1;
    check("bb_rv1",  rv_v(), 32'h1);
    check("bb_rd1",  host_rdata[0], exp_q.pop_front());
    check("bb_err1", err_v(), 32'h0);

    // Overlapping windows: timer also covers RAM range, RAM must win.
    @(negedge clk);
    cfg_base[2] = 32'h00100000;
    cfg_mask[2] = 32'hFFF00000;
    drive(0, 1'b1, 32'h00100040, 1'b0);
    #1;
    check("ov_dreq", dreq_v(), 32'h1);
    @(negedge clk);
    set_default_map();
    drive(0, 1'b0, 32'h0, 1'b0);
    #1;
    check("ov_rd", host_rdata[0], 32'hDEADBEEF);
    check("ov_ptr", 32'(dbg_ptr), 32'h1);

    // Device fails to answer: host still gets rvalid with err and zero data.
    @(negedge clk);
    dev_silent[0] = 1'b1;
    drive(1, 1'b1, 32'h00100040, 1'b0);
    #1;
    check("sl_gnt",  gnt_v(),  32'h2);
    check("sl_dreq", dreq_v(), 32'h1);
    @(negedge clk);
    drive(1, 1'b0, 32'h0, 1'b0);
    #1;
    check("sl_rv",  rv_v(),  32'h2);
    check("sl_err", err_v(), 32'h2);
    check("sl_rd",  host_rdata[1], 32'h0);
    dev_silent[0] = 1'b0;

    // Reset the cycle after a grant: response dropped, pointer back to 0.
    @(negedge clk);
    drive(0, 1'b1, 32'h00100040, 1'b0);
    #1;
    check("rm_gnt", gnt_v(), 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 1'b0, 32'h0, 1'b0);
    #1;
    check("rm_rv",  rv_v(),  32'h0);
    check("rm_err", err_v(), 32'h0);
    check("rm_rd0", host_rdata[0], 32'h0);
    @(negedge clk);
    drive(0, 1'b1, 32'h00100040, 1'b0);
    drive(1, 1'b1, 32'h00100040, 1'b0);
    #1;
    check("rm_gnt_rst", gnt_v(), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rm_ptr",      32'(dbg_ptr), 32'h0);
    check("rm_gnt_post", gnt_v(), 32'h1);
    check("rm_rv_post",  rv_v(),  32'h0);
    @(negedge clk);
    drive(0, 1'b0, 32'h0, 1'b0);
    drive(1, 1'b0, 32'h0, 1'b0);
    #1;
    check("rm_rv_next", rv_v(), 32'h1);
    check("rm_rd_next", host_rdata[0], 32'hDEADBEEF);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
